// File: rtl/pinball_pkg.sv
// pinball_pkg: shared definitions for the pinball game sequencer and the
// scoring block, so both sides decode the state bus identically.
//   game_state_t : encodings driven on the shared 3-bit state bus
//   HOLE_W       : number of hole sensors (width of hole_hit / getball)
package pinball_pkg;

  localparam int HOLE_W = 8;

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_WAIT  = 3'd1,
    ST_START = 3'd2,
    ST_GET   = 3'd3,
    ST_OVER  = 3'd4
  } game_state_t;

endpackage

// File: rtl/ball_timer.sv
// ball_timer: counts cycles a ball has been in play.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force count to 0 (held while no ball is in play)
//   en       : count one cycle
//   expired  : level, high while count == TIMEOUT-1
module ball_timer #(
  parameter int TIMEOUT = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt;

  assign expired = (cnt == W'(TIMEOUT - 1));

  // Saturate at the terminal count so a held enable never wraps back to 0.
  always_ff @(posedge clk) begin
    if (rst || clr)          cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pinball_game_ctrl.sv
// pinball_game_ctrl: game sequencer. Walks each game RESET->WAIT->START->
// GET->...->OVER, picks the scoring group, latches hole hits for the scorer,
// counts the ball budget and times out balls that never reach a hole.
//   clk, rst        : clock, synchronous active-high reset
//   start_btn       : one-cycle start pulse
//   hole_hit[7:0]   : one-cycle hole sensor pulses
//   state[2:0]      : registered game state (pinball_pkg encodings)
//   selected_group  : registered scoring group captured at launch
//   getball[7:0]    : latched hole vector, non-zero only in GET
//   balls_left[3:0] : balls remaining in the current game
//   ball_lost       : one-cycle pulse on ball timeout
module pinball_game_ctrl
  import pinball_pkg::*;
#(
  parameter int BALLS   = 3,
  parameter int TIMEOUT = 100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_btn,
  input  logic [HOLE_W-1:0] hole_hit,
  output logic [2:0]        state,
  output logic [2:0]        selected_group,
  output logic [HOLE_W-1:0] getball,
  output logic [3:0]        balls_left,
  output logic              ball_lost
);

  game_state_t       st_q, st_nxt;
  logic [2:0]        grp_q, grp_nxt;
  logic [2:0]        sel_nxt;
  logic [HOLE_W-1:0] get_nxt;
  logic [3:0]        balls_nxt;
  logic              lost_nxt;
  logic              expired;

  assign state = st_q;

  // Timer is held at 0 outside START, so it always starts fresh on launch.
  ball_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (st_q != ST_START),
    .en      (st_q == ST_START),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q           <= ST_RESET;
      grp_q          <= '0;
      selected_group <= '0;
      getball        <= '0;
      balls_left     <= '0;
      ball_lost      <= 1'b0;
    end else begin
      st_q           <= st_nxt;
      grp_q          <= grp_nxt;
      selected_group <= sel_nxt;
      getball        <= get_nxt;
      balls_left     <= balls_nxt;
      ball_lost      <= lost_nxt;
    end
  end

  always_comb begin
    st_nxt    = st_q;
    grp_nxt   = grp_q;
    sel_nxt   = selected_group;
    get_nxt   = '0;
    balls_nxt = balls_left;
    lost_nxt  = 1'b0;
    case (st_q)
      ST_RESET: begin
        balls_nxt = 4'(BALLS);
        st_nxt    = ST_WAIT;
      end
      ST_WAIT: begin
        grp_nxt = grp_q + 3'd1;
        if (start_btn) begin
          sel_nxt = grp_q;
          st_nxt  = ST_START;
        end
      end
      ST_START: begin
        // A hit on the expiry cycle still scores: hit is checked first.
        if (hole_hit != '0) begin
          get_nxt = hole_hit;
          st_nxt  = ST_GET;
        end else if (expired) begin
          lost_nxt  = 1'b1;
          balls_nxt = balls_left - 4'd1;
          st_nxt    = (balls_left == 4'd1) ? ST_OVER : ST_WAIT;
        end
      end
      ST_GET: begin
        balls_nxt = balls_left - 4'd1;
        st_nxt    = (balls_left == 4'd1) ? ST_OVER : ST_WAIT;
      end
      ST_OVER: begin
        balls_nxt = '0;
        if (start_btn) st_nxt = ST_RESET;
      end
      default: st_nxt = ST_RESET;
    endcase
  end

endmodule

// File: tb/tb_pinball_game_ctrl.sv
module tb_pinball_game_ctrl;

  localparam int BALLS   = 3;
  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_btn = 1'b0;
  logic [7:0] hole_hit = 8'h00;
  logic [2:0] state;
  logic [2:0] selected_group;
  logic [7:0] getball;
  logic [3:0] balls_left;
  logic       ball_lost;

  int errors = 0;
  int checks = 0;

  // Reference model: game-level bookkeeping, updated once per clock edge.
  int m_state, m_grp, m_sel, m_get, m_balls, m_lost, m_age;

  pinball_game_ctrl #(.BALLS(BALLS), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_btn      (start_btn),
    .hole_hit       (hole_hit),
    .state          (state),
    .selected_group (selected_group),
    .getball        (getball),
    .balls_left     (balls_left),
    .ball_lost      (ball_lost)
  );

  always #5 clk = ~clk;

  // States: 0 RESET, 1 WAIT, 2 START (ball in play), 3 GET, 4 OVER.
  task automatic model_edge(input logic s, input logic [7:0] h, input logic r);
    int ns;
    ns = m_state;
    m_lost = 0;
    if (r) begin
      ns = 0; m_grp = 0; m_sel = 0; m_get = 0; m_balls = 0; m_age = 0;
    end else if (m_state == 0) begin
      m_balls = BALLS; m_get = 0; ns = 1;
    end else if (m_state == 1) begin
      if (s) begin m_sel = m_grp; m_age = 0; ns = 2; end
      m_grp = (m_grp + 1) % 8;
    end else if (m_state == 2) begin
      m_age = m_age + 1;
      if (h != 0) begin
        m_get = h; ns = 3;
      end else if (m_age == TIMEOUT) begin
        m_lost = 1; m_balls = m_balls - 1;
        ns = (m_balls == 0) ? 4 : 1;
      end
    end else if (m_state == 3) begin
      m_get = 0; m_balls = m_balls - 1;
      ns = (m_balls == 0) ? 4 : 1;
    end else begin
      m_balls = 0;
      if (s) ns = 0;
    end
    m_state = ns;
  endtask

  task automatic step(input logic s, input logic [7:0] h, input logic r);
    start_btn = s; hole_hit = h; rst = r;
    @(posedge clk);
    model_edge(s, h, r);
    #1;
    start_btn = 1'b0; hole_hit = 8'h00; rst = 1'b0;
  endtask

  task automatic test_reset;
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if ({state, selected_group, getball, balls_left, ball_lost} !== 19'd0) begin
      errors++;
      $display("FAIL reset got state=%0d grp=%0d get=%h balls=%0d lost=%0d exp all 0",
               state, selected_group, getball, balls_left, ball_lost);
    end
  endtask

  task automatic test_launch;
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (state !== 3'd1 || balls_left !== 4'd3) begin
      errors++; $display("FAIL reset_to_wait got state=%0d balls=%0d exp 1/3", state, balls_left);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0);
    checks++;
    if (state !== 3'd1) begin
      errors++; $display("FAIL wait_hold got state=%0d exp 1", state);
    end
    step(1'b1, 8'h00, 1'b0);
    checks++;
    if (state !== 3'd2 || selected_group !== 3'd5 || balls_left !== 4'd3) begin
      errors++; $display("FAIL launch got state=%0d grp=%0d balls=%0d exp 2/5/3",
                         state, selected_group, balls_left);
    end
  endtask

  task automatic test_hole_get;
    step(1'b0, 8'h05, 1'b0);
    checks++;
    if (state !== 3'd3 || getball !== 8'h05) begin
      errors++; $display("FAIL hole_get got state=%0d get=%h exp 3/05", state, getball);
    end
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (state !== 3'd1 || getball !== 8'h00 || balls_left !== 4'd2) begin
      errors++; $display("FAIL after_get got state=%0d get=%h balls=%0d exp 1/00/2",
                         state, getball, balls_left);
    end
  endtask

  task automatic test_timeout;
    step(1'b1, 8'h00, 1'b0);
    for (int i = 1; i < TIMEOUT; i++) begin
      step(1'b0, 8'h00, 1'b0);
      checks++;
      if (ball_lost !== 1'b0 || state !== 3'd2) begin
        errors++; $display("FAIL early_timeout cyc=%0d got lost=%0d state=%0d exp 0/2",
                           i, ball_lost, state);
      end
    end
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (ball_lost !== 1'b1 || state !== 3'd1 || balls_left !== 4'd1 || getball !== 8'h00) begin
      errors++; $display("FAIL timeout got lost=%0d state=%0d balls=%0d get=%h exp 1/1/1/00",
                         ball_lost, state, balls_left, getball);
    end
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (ball_lost !== 1'b0) begin
      errors++; $display("FAIL lost_pulse_width got lost=%0d exp 0", ball_lost);
    end
  endtask

  task automatic test_hit_on_timeout;
    step(1'b1, 8'h00, 1'b0);
    for (int i = 1; i < TIMEOUT; i++) step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h80, 1'b0);
    checks++;
    if (state !== 3'd3 || getball !== 8'h80 || ball_lost !== 1'b0) begin
      errors++; $display("FAIL hit_wins got state=%0d get=%h lost=%0d exp 3/80/0",
                         state, getball, ball_lost);
    end
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (state !== 3'd4 || balls_left !== 4'd0 || ball_lost !== 1'b0) begin
      errors++; $display("FAIL game_over got state=%0d balls=%0d lost=%0d exp 4/0/0",
                         state, balls_left, ball_lost);
    end
  endtask

  task automatic test_over_restart;
    step(1'b0, 8'h3c, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (state !== 3'd4 || balls_left !== 4'd0 || getball !== 8'h00) begin
      errors++; $display("FAIL over_hold got state=%0d balls=%0d get=%h exp 4/0/00",
                         state, balls_left, getball);
    end
    step(1'b1, 8'h00, 1'b0);
    checks++;
    if (state !== 3'd0) begin
      errors++; $display("FAIL over_restart got state=%0d exp 0", state);
    end
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (state !== 3'd1 || balls_left !== 4'd3) begin
      errors++; $display("FAIL new_game got state=%0d balls=%0d exp 1/3", state, balls_left);
    end
  endtask

  task automatic test_back_to_back;
    step(1'b1, 8'hff, 1'b0);
    checks++;
    if (state !== 3'd2 || getball !== 8'h00) begin
      errors++; $display("FAIL launch_with_hit got state=%0d get=%h exp 2/00", state, getball);
    end
  endtask

  task automatic test_reset_in_get;
    step(1'b0, 8'h01, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if (state !== 3'd0 || getball !== 8'h00 || balls_left !== 4'd0 || selected_group !== 3'd0) begin
      errors++; $display("FAIL reset_in_get got state=%0d get=%h balls=%0d grp=%0d exp 0/00/0/0",
                         state, getball, balls_left, selected_group);
    end
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (state !== 3'd1 || balls_left !== 4'd3) begin
      errors++; $display("FAIL after_reset got state=%0d balls=%0d exp 1/3", state, balls_left);
    end
  endtask

  task automatic test_random;
    logic       s, r;
    logic [7:0] h;
    logic [18:0] exp_v, got_v;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 59) == 0);
      s = ($urandom_range(0, 3) == 0);
      h = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      step(s, h, r);
      exp_v = {3'(m_state), 3'(m_sel), 8'(m_get), 4'(m_balls), 1'(m_lost)};
      got_v = {state, selected_group, getball, balls_left, ball_lost};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL random cyc=%0d got st=%0d grp=%0d get=%h balls=%0d lost=%0d exp st=%0d grp=%0d get=%h balls=%0d lost=%0d",
                 i, state, selected_group, getball, balls_left, ball_lost,
                 m_state, m_sel, m_get, m_balls, m_lost);
      end
    end
  endtask

  initial begin
    m_state = 0; m_grp = 0; m_sel = 0; m_get = 0; m_balls = 0; m_lost = 0; m_age = 0;
    test_reset;
    test_launch;
    test_hole_get;
    test_timeout;
    test_hit_on_timeout;
    test_over_restart;
    test_back_to_back;
    test_reset_in_get;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
